// File: rtl/arbitro_multiplicacion_torus_pkg.sv
// Shared definitions for the round-robin 2x2 torus multiplier arbiter:
// state encoding, coefficient widths, packing offsets and default sizing.
package arbitro_multiplicacion_torus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CARGA   = 2'd1,
    ESPERA  = 2'd2,
    ENTREGA = 2'd3
  } state_t;

  localparam int CW_IN  = 4;
  localparam int CW_OUT = 8;
  localparam int OPS_W  = 8 * CW_IN;
  localparam int MAT_W  = 4 * CW_IN;
  localparam int RES_W  = 4 * CW_OUT;

  // Bit offsets of each coefficient inside an OPS word (A00 in the MSBs)
  localparam int OFF_A00 = 28;
  localparam int OFF_A01 = 24;
  localparam int OFF_A10 = 20;
  localparam int OFF_A11 = 16;
  localparam int OFF_B00 = 12;
  localparam int OFF_B01 = 8;
  localparam int OFF_B10 = 4;
  localparam int OFF_B11 = 0;
  localparam int OFF_MA  = OFF_A11;
  localparam int OFF_MB  = OFF_B11;

  // Bit offsets of each product coefficient inside RES/MC (C00 in the MSBs)
  localparam int OFF_C00 = 24;
  localparam int OFF_C01 = 16;
  localparam int OFF_C10 = 8;
  localparam int OFF_C11 = 0;

  localparam int NREQ_DEF    = 4;
  localparam int TIMEOUT_DEF = 31;

endpackage

// File: rtl/arbitro_multiplicacion_torus_selector_rr.sv
// Combinational round-robin picker: first set request bit searching upward
// from i_ptr+1 with wrap-around; returns a one-hot grant and its index.
module arbitro_multiplicacion_torus_selector_rr #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  logic [IW-1:0] w_pos;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_pos = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_pos = ((int'(i_ptr) + k) >= NREQ) ? IW'(int'(i_ptr) + k - NREQ)
                                          : IW'(int'(i_ptr) + k);
      if (!o_any && i_req[w_pos]) begin
        o_any = 1'b1;
        o_idx = w_pos;
        o_gnt = NREQ'(1) << w_pos;
      end
    end
  end

endmodule

// File: rtl/arbitro_multiplicacion_torus.sv
// Round-robin scheduler sharing one 2x2 torus matrix multiplier (STM/EOM handshake).
// Optional EOM watchdog compiled in with ARB_TIMEOUT_EN.
module arbitro_multiplicacion_torus
  import arbitro_multiplicacion_torus_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*OPS_W-1:0] OPS,
  output logic [NREQ-1:0]       GNT,
  output logic                  BUSY,
  output logic [NREQ-1:0]       DONE,
  output logic                  ERR,
  output logic [RES_W-1:0]      RES,
  output logic                  STM,
  output logic [MAT_W-1:0]      MA,
  output logic [MAT_W-1:0]      MB,
  input  logic                  EOM,
  input  logic [RES_W-1:0]      MC
);

  localparam int IW = $clog2(NREQ);

  state_t           r_state;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_idx;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_done;
  logic             r_stm;
  logic             r_busy;
  logic [RES_W-1:0] r_res;
  logic [MAT_W-1:0] r_ma;
  logic [MAT_W-1:0] r_mb;

  logic [NREQ-1:0]  w_sel_gnt;
  logic [IW-1:0]    w_sel_idx;
  logic             w_sel_any;
  logic [OPS_W-1:0] w_ops [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_ops
    assign w_ops[i] = OPS[i*OPS_W +: OPS_W];
  end

  arbitro_multiplicacion_torus_selector_rr #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_selector_rr (
    .i_req (REQ),
    .i_ptr (r_ptr),
    .o_gnt (w_sel_gnt),
    .o_idx (w_sel_idx),
    .o_any (w_sel_any)
  );

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_err;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        CARGA:   r_cnt <= '0;
        ESPERA: begin
          r_cnt <= r_cnt + 8'd1;
          // EOM has priority over an expiring watchdog
          r_err <= !EOM && (r_cnt == 8'(TIMEOUT - 1));
        end
        default: r_err <= 1'b0;
      endcase
    end
  end

  wire w_timeout = (r_cnt == 8'(TIMEOUT - 1));
  assign ERR = r_err;
`else
  wire w_timeout = 1'b0;
  assign ERR = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= IDLE;
      r_ptr   <= IW'(NREQ - 1);
      r_idx   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_stm   <= 1'b0;
      r_busy  <= 1'b0;
      r_res   <= '0;
      r_ma    <= '0;
      r_mb    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_sel_any) begin
            r_gnt   <= w_sel_gnt;
            r_idx   <= w_sel_idx;
            r_ma    <= w_ops[w_sel_idx][OFF_MA +: MAT_W];
            r_mb    <= w_ops[w_sel_idx][OFF_MB +: MAT_W];
            r_stm   <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= CARGA;
          end
        end
        CARGA: begin
          r_stm   <= 1'b0;
          r_state <= ESPERA;
        end
        ESPERA: begin
          if (EOM) begin
            r_res   <= MC;
            r_done  <= r_gnt;
            r_state <= ENTREGA;
          end else if (w_timeout) begin
            r_res   <= '0;
            r_done  <= r_gnt;
            r_state <= ENTREGA;
          end
        end
        ENTREGA: begin
          r_done  <= '0;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_ptr   <= r_idx;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign GNT  = r_gnt;
  assign DONE = r_done;
  assign BUSY = r_busy;
  assign STM  = r_stm;
  assign RES  = r_res;
  assign MA   = r_ma;
  assign MB   = r_mb;

endmodule

// File: tb/tb_arbitro_multiplicacion_torus.sv
// Self-checking bench for arbitro_multiplicacion_torus: directed scenarios plus
// randomized traffic scored against a round-robin / matrix-product reference model.
module tb_arbitro_multiplicacion_torus;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 31;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic [NREQ-1:0]   REQ = '0;
  logic [NREQ*32-1:0] OPS = '0;
  logic [NREQ-1:0]   GNT;
  logic              BUSY;
  logic [NREQ-1:0]   DONE;
  logic              ERR;
  logic [31:0]       RES;
  logic              STM;
  logic [15:0]       MA;
  logic [15:0]       MB;
  logic              EOM = 1'b0;
  logic [31:0]       MC  = '0;

  arbitro_multiplicacion_torus #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .OPS(OPS), .GNT(GNT), .BUSY(BUSY),
    .DONE(DONE), .ERR(ERR), .RES(RES), .STM(STM), .MA(MA), .MB(MB),
    .EOM(EOM), .MC(MC)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // 2x2 product of the A and B matrices packed in a 32-bit operand word, 8-bit wrap
  function automatic logic [31:0] mat_mul(input logic [31:0] w);
    int a [2][2];
    int b [2][2];
    int c [2][2];
    logic [31:0] r;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        a[i][j] = int'(w[31 - 4*(2*i+j) -: 4]);
        b[i][j] = int'(w[15 - 4*(2*i+j) -: 4]);
      end
    r = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        c[i][j] = a[i][0]*b[0][j] + a[i][1]*b[1][j];
        r[31 - 8*(2*i+j) -: 8] = 8'(c[i][j] % 256);
      end
    return r;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] req, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (req[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  // Multiplier stand-in: EOM pulses mul_lat cycles after the STM cycle
  int          mul_lat = 4;
  bit          mul_en  = 1'b1;
  int          mul_cnt = 0;
  logic [31:0] mul_res = '0;

  always @(posedge CLK) begin
    #1;
    EOM = 1'b0;
    if (!BUSY) mul_cnt = 0;
    if (mul_cnt > 0) begin
      mul_cnt--;
      if (mul_cnt == 0) begin
        EOM = 1'b1;
        MC  = mul_res;
      end
    end
    if (STM && mul_en) begin
      mul_cnt = mul_lat;
      mul_res = mat_mul({MA, MB});
    end
  end

  // Reference model / scoreboard, evaluated on the falling edge
  int              m_last = NREQ - 1;
  int              m_win  = 0;
  bit              m_busy = 1'b0;
  logic [31:0]     m_ops  = '0;
  logic [NREQ-1:0] p_req  = '0;
  logic [NREQ*32-1:0] p_ops = '0;
  logic [NREQ-1:0] p_gnt  = '0;
  logic [NREQ-1:0] p_done = '0;
  int              served_q [$];

  always @(negedge CLK) begin
    if (!RST) begin
      m_last = NREQ - 1;
      m_busy = 1'b0;
    end else begin
      chk("gnt_onehot", 32'($countones(GNT) <= 1), 32'd1);
      if (GNT != '0 && p_gnt == '0) begin
        m_win = rr_pick(p_req, m_last);
        chk("gnt_winner", 32'(GNT), 32'(NREQ'(1) << m_win));
        m_ops = p_ops[m_win*32 +: 32];
        chk("ma_latch", 32'(MA), 32'(m_ops[31:16]));
        chk("mb_latch", 32'(MB), 32'(m_ops[15:0]));
        m_busy = 1'b1;
      end
      if (DONE != '0) begin
        chk("done_target", 32'(DONE), m_busy ? 32'(NREQ'(1) << m_win) : 32'd0);
        chk("done_pulse", 32'(p_done), 32'd0);
        chk("res_value", RES, ERR ? 32'd0 : mat_mul(m_ops));
        chk("ma_stable", 32'(MA), 32'(m_ops[31:16]));
        served_q.push_back(m_win);
        m_last = m_win;
        m_busy = 1'b0;
      end
    end
    p_req  = REQ;
    p_ops  = OPS;
    p_gnt  = GNT;
    p_done = DONE;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_done(input int maxc, output int n);
    n = 0;
    for (int i = 1; i <= maxc; i++) begin
      step();
      if (DONE != '0) begin
        n = i;
        return;
      end
    end
    chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (!BUSY && GNT == '0) return;
      step();
    end
    chk("idle_timeout", 32'(BUSY), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},  32'(GNT),  32'd0);
    chk({tag, "_done"}, 32'(DONE), 32'd0);
    chk({tag, "_err"},  32'(ERR),  32'd0);
    chk({tag, "_stm"},  32'(STM),  32'd0);
    chk({tag, "_busy"}, 32'(BUSY), 32'd0);
    chk({tag, "_res"},  RES,       32'd0);
    chk({tag, "_ma"},   32'(MA),   32'd0);
    chk({tag, "_mb"},   32'(MB),   32'd0);
  endtask

  int n;
  int seen;

  initial begin
    // Reset state
    step(); step();
    chk_all_zero("reset");
    RST = 1'b1;

    // Single request: exact timing and product
    OPS = {$urandom, $urandom, $urandom, 32'h1234_5678};
    REQ = 4'b0001;
    step();
    chk("single_gnt", 32'(GNT), 32'h1);
    chk("single_stm", 32'(STM), 32'd1);
    chk("single_busy", 32'(BUSY), 32'd1);
    chk("single_ma", 32'(MA), 32'h1234);
    chk("single_mb", 32'(MB), 32'h5678);
    REQ = '0;
    step();
    chk("single_stm_1cyc", 32'(STM), 32'd0);
    wait_done(40, n);
    chk("single_latency", 32'(n + 1), 32'd5);
    chk("single_done", 32'(DONE), 32'h1);
    chk("single_res", RES, 32'h1316_2B32);
    chk("single_err", 32'(ERR), 32'd0);
    step();
    chk("single_done_clr", 32'(DONE), 32'd0);
    chk("single_res_hold", RES, 32'h1316_2B32);
    wait_idle(10);

    // Contention with all requesters held, starting from reset pointer
    RST = 1'b0; step(); RST = 1'b1;
    served_q.delete();
    OPS = {$urandom, $urandom, $urandom, $urandom};
    REQ = 4'b1111;
    seen = 0;
    for (int i = 0; i < 300 && seen < 5; i++) begin
      step();
      if (DONE != '0) seen++;
    end
    REQ = '0;
    chk("cont_count", 32'(seen), 32'd5);
    wait_idle(20);
    for (int i = 0; i < 5; i++)
      chk("cont_order", (i < served_q.size()) ? 32'(served_q[i]) : 32'hFFFF_FFFF, 32'(i % 4));

    // Operand stability: OPS changes right after the grant
    OPS[31:0] = 32'h1234_5678;
    REQ = 4'b0001;
    step();
    chk("stab_gnt", 32'(GNT), 32'h1);
    OPS[31:0] = 32'hFEDC_BA98;
    REQ = '0;
    wait_done(40, n);
    chk("stab_ma", 32'(MA), 32'h1234);
    chk("stab_mb", 32'(MB), 32'h5678);
    chk("stab_res", RES, 32'h1316_2B32);
    wait_idle(10);

    // REQ dropped while in CARGA
    REQ = 4'b0010;
    step();
    chk("drop_gnt", 32'(GNT), 32'h2);
    REQ = '0;
    wait_done(40, n);
    chk("drop_done", 32'(DONE), 32'h2);
    wait_idle(10);

    // Reset while waiting for EOM
    REQ = 4'b0001;
    step();
    REQ = '0;
    step();
    RST = 1'b0;
    step();
    chk_all_zero("rst_mid");
    RST = 1'b1;
    REQ = 4'b0100;
    step();
    chk("rst_next_gnt", 32'(GNT), 32'h4);
    REQ = '0;
    wait_done(40, n);
    chk("rst_next_done", 32'(DONE), 32'h4);
    wait_idle(10);

    // Randomized traffic scored by the falling-edge model
    for (int i = 0; i < 400; i++) begin
      OPS = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(3) == 0) REQ = NREQ'($urandom);
      mul_lat = int'($urandom_range(6, 1));
      step();
    end
    REQ = '0;
    wait_idle(100);

`ifdef ARB_TIMEOUT_EN
    // Watchdog expiry with no EOM
    mul_en = 1'b0;
    REQ = 4'b1000;
    step();
    REQ = '0;
    wait_done(60, n);
    chk("to_latency", 32'(n), 32'd32);
    chk("to_err", 32'(ERR), 32'd1);
    chk("to_res", RES, 32'd0);
    step();
    chk("to_err_clr", 32'(ERR), 32'd0);
    wait_idle(10);
    // EOM on the final watchdog cycle wins
    mul_en = 1'b1;
    mul_lat = TIMEOUT;
    OPS[31:0] = 32'h1234_5678;
    REQ = 4'b0001;
    step();
    REQ = '0;
    wait_done(60, n);
    chk("to_eom_latency", 32'(n), 32'd32);
    chk("to_eom_err", 32'(ERR), 32'd0);
    chk("to_eom_res", RES, 32'h1316_2B32);
    wait_idle(10);
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/arbitro_multiplicacion_torus.md
# arbitro_multiplicacion_torus

Round-robin scheduler that shares one 2x2 torus matrix multiplier among NREQ requesters. It latches the winning requester's A/B coefficients and drives them to the multiplier. It issues the start pulse, waits for end-of-multiplication, then returns the 4-coefficient product with a per-requester done pulse. It sits between client logic and the multiplier top, which it treats as a black box with STM/EOM handshake.

## Interface
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 31, max cycles waited for EOM (used only with watchdog compiled in)
- CLK  in  1  master clock, rising edge
- RST  in  1  reset, synchronous, active-low
- REQ  in  NREQ  level request, one bit per requester
- OPS  in  NREQ*32  per requester i at [32i+31:32i]: A00,A01,A10,A11,B00,B01,B10,B11, 4 bits each, A00 in MSBs
- GNT  out  NREQ  one-hot grant, held from grant to delivery
- BUSY  out  1  any operation in flight
- DONE  out  NREQ  one-cycle pulse to the served requester
- ERR  out  1  one-cycle pulse with DONE when the operation timed out
- RES  out  32  C00,C01,C10,C11, 8 bits each, C00 in MSBs; valid while DONE!=0, held until next delivery
- STM  out  1  start pulse to multiplier
- MA  out  16  A coefficients to multiplier, same packing as OPS
- MB  out  16  B coefficients to multiplier
- EOM  in  1  end-of-multiplication from multiplier
- MC  in  32  product from multiplier, same packing as RES

## Operation
- States: IDLE, CARGA, ESPERA, ENTREGA.
- IDLE: if REQ!=0, pick the first set bit searching upward from ptr+1 (wrap-around); set GNT, latch that requester's OPS into MA/MB, go to CARGA; else stay.
- CARGA: STM=1 for exactly this cycle; go to ESPERA.
- ESPERA: STM=0; on EOM=1 latch MC into RES, go to ENTREGA.
- ENTREGA: DONE[g]=1, GNT cleared at exit, ptr<=g; go to IDLE.
- MA/MB are stable from CARGA through ENTREGA; OPS changes after the latch are ignored.
- REQ dropped mid-operation has no effect; the operation completes and DONE still pulses.
- EOM during IDLE or CARGA is ignored.
- A requester holding REQ high after DONE is re-served only after all other active requesters have been served (fairness).
- Products are not recomputed here: RES is MC verbatim (unsigned 4x4 coefficient products summed in 8 bits, per multiplier).
- Reset (RST=0 at an edge), including mid-operation: state IDLE, ptr=NREQ-1 (so requester 0 wins first), and GNT, DONE, ERR, STM, BUSY, RES, MA, MB all 0.

## Timing
- All outputs registered.
- REQ sampled at edge k in IDLE: GNT and MA/MB valid after k, STM high during cycle k+1.
- EOM sampled high at edge m: DONE and RES valid during cycle m+1.
- Minimum request-to-DONE latency is 3 cycles, plus the multiplier's own latency.
- Earliest next grant is at the edge following ENTREGA, so there is one IDLE cycle between operations.
- BUSY=1 in CARGA, ESPERA and ENTREGA.

## Configuration
- ARB_TIMEOUT_EN defined:
  - An 8-bit counter clears on entering ESPERA and increments each ESPERA cycle.
  - If it reaches TIMEOUT without EOM, go to ENTREGA with RES=0 and ERR=1 alongside DONE.
  - EOM and timeout in the same cycle: EOM wins, ERR=0.
- ARB_TIMEOUT_EN undefined: ESPERA waits indefinitely, no counter is built, and ERR is tied to 0.

## Structure
- Shared package holds:
  - state encoding (2 bits)
  - coefficient widths (4 in, 8 out)
  - per-coefficient slice offsets in the 32-bit OPS/RES packing
  - default NREQ and TIMEOUT
- One sub-module, selector_rr: combinational round-robin picker taking REQ and ptr, producing a one-hot grant and its index.

## Test plan
- Single request: REQ=0001, OPS[31:0]=A{1,2,3,4} B{5,6,7,8}. Multiplier model has EOM 4 cycles after STM. Required: RES=C{19,22,43,50}, i.e. 0x13162B32; DONE=0001 at exactly cycle STM+5; STM high exactly one cycle.
- Contention: REQ=1111 held. Required grant order is 0,1,2,3,0; each DONE is a single pulse; GNT is never more than one-hot.
- Operand stability: change OPS[0] one cycle after GNT. Required: MA/MB unchanged and RES computed from the original operands.
- Reset mid-ESPERA: drive RST=0 for one edge. Required: all outputs 0 next cycle, no DONE, and the next REQ=0100 is granted to requester 2.
- With ARB_TIMEOUT_EN, TIMEOUT=31 and EOM never asserted. Required: DONE and ERR pulse together 32 cycles after STM with RES=0, then IDLE. EOM on the final timeout cycle gives ERR=0.
- REQ dropped in CARGA: the operation still completes and DONE pulses for that requester.
